// File: rtl/vx_gpr_read_ctrl_pkg.sv
// Shared types and sizing for the GPR operand read controller.
package vx_gpr_pkg;
    localparam int NUM_THREADS = 4;
    localparam int NUM_WARPS   = 4;
    localparam int NUM_REGS    = 32;
    localparam int TAG_WIDTH   = 8;
    localparam int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int REG_W       = $clog2(NUM_REGS);
    localparam int RF_ADDR_W   = WID_W + REG_W;
    localparam int NUM_OPS     = 3;

    typedef logic [NUM_THREADS*32-1:0] operand_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAP12 = 2'd1,
        CAP3  = 2'd2,
        RSP   = 2'd3
    } gpr_state_e;

    // Bank address is the warp id on top of the register index.
    function automatic logic [RF_ADDR_W-1:0] rf_addr(input logic [WID_W-1:0] wid,
                                                     input logic [REG_W-1:0] rgi);
        return {wid, rgi};
    endfunction
endpackage

// File: rtl/vx_gpr_read_ctrl_if.sv
// Request, bank and response signals of the operand read controller.
interface vx_gpr_read_ctrl_if;
    import vx_gpr_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic [WID_W-1:0]       req_wid;
    logic [REG_W-1:0]       req_rs1;
    logic [REG_W-1:0]       req_rs2;
    logic [REG_W-1:0]       req_rs3;
    logic                   req_use_rs3;
    logic [TAG_WIDTH-1:0]   req_tag;

    logic                   rf_ren;
    logic [RF_ADDR_W-1:0]   rf_raddr_a;
    logic [RF_ADDR_W-1:0]   rf_raddr_b;
    operand_t               rf_rdata_a;
    operand_t               rf_rdata_b;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WID_W-1:0]       rsp_wid;
    logic [TAG_WIDTH-1:0]   rsp_tag;
    operand_t               rsp_rs1_data;
    operand_t               rsp_rs2_data;
    operand_t               rsp_rs3_data;

    // Environment side: issues requests, owns the bank, consumes responses.
    modport master (
        output req_valid, req_wid, req_rs1, req_rs2, req_rs3, req_use_rs3, req_tag,
        input  req_ready,
        input  rf_ren, rf_raddr_a, rf_raddr_b,
        output rf_rdata_a, rf_rdata_b,
        input  rsp_valid, rsp_wid, rsp_tag, rsp_rs1_data, rsp_rs2_data, rsp_rs3_data,
        output rsp_ready
    );

    // Controller side.
    modport slave (
        input  req_valid, req_wid, req_rs1, req_rs2, req_rs3, req_use_rs3, req_tag,
        output req_ready,
        output rf_ren, rf_raddr_a, rf_raddr_b,
        input  rf_rdata_a, rf_rdata_b,
        output rsp_valid, rsp_wid, rsp_tag, rsp_rs1_data, rsp_rs2_data, rsp_rs3_data,
        input  rsp_ready
    );
endinterface

// File: rtl/vx_gpr_read_ctrl_operand_reg.sv
// One operand capture register: clear wins, then load, with x0 forced to zero.
module vx_gpr_operand_reg
    import vx_gpr_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     en,
    input  logic     clr,
    input  logic     idx_zero,
    input  operand_t d,
    output operand_t q
);
    // Hold until a capture or a clear; x0 reads never take bank data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   q <= '0;
        else if (clr)   q <= '0;
        else if (en)    q <= idx_zero ? '0 : d;
    end
endmodule

// File: rtl/vx_gpr_read_ctrl.sv
// Operand read sequencer: rs1/rs2 on both bank ports, then rs3 on port A
// when needed, and a registered response held until the consumer takes it.
module vx_gpr_read_ctrl
    import vx_gpr_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    vx_gpr_read_ctrl_if.slave  bus,
    output logic               busy
);
    gpr_state_e             state_q, state_d;
    logic [WID_W-1:0]       wid_q;
    logic [REG_W-1:0]       rs1_idx_q, rs2_idx_q, rs3_idx_q;
    logic                   use_rs3_q;
    logic [TAG_WIDTH-1:0]   tag_q;

    logic                   fire, cap12, cap3, ren;
    logic [RF_ADDR_W-1:0]   addr_a, addr_b;

    operand_t [NUM_OPS-1:0] op_d, op_q;
    logic     [NUM_OPS-1:0] op_en, op_clr, op_zero;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state, bank read port drive and handshake; flush overrides all.
    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        cap12   = 1'b0;
        cap3    = 1'b0;
        ren     = 1'b0;
        addr_a  = '0;
        addr_b  = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && !flush) begin
                    fire    = 1'b1;
                    ren     = 1'b1;
                    addr_a  = rf_addr(bus.req_wid, bus.req_rs1);
                    addr_b  = rf_addr(bus.req_wid, bus.req_rs2);
                    state_d = CAP12;
                end
            end
            CAP12: begin
                cap12 = 1'b1;
                if (use_rs3_q) begin
                    ren     = 1'b1;
                    addr_a  = rf_addr(wid_q, rs3_idx_q);
                    state_d = CAP3;
                end else begin
                    state_d = RSP;
                end
            end
            CAP3: begin
                cap3    = 1'b1;
                state_d = RSP;
            end
            RSP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Latch request context on acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wid_q     <= '0;
            rs1_idx_q <= '0;
            rs2_idx_q <= '0;
            rs3_idx_q <= '0;
            use_rs3_q <= 1'b0;
            tag_q     <= '0;
        end else if (fire) begin
            wid_q     <= bus.req_wid;
            rs1_idx_q <= bus.req_rs1;
            rs2_idx_q <= bus.req_rs2;
            rs3_idx_q <= bus.req_rs3;
            use_rs3_q <= bus.req_use_rs3;
            tag_q     <= bus.req_tag;
        end
    end

    // rs3 is sourced from port A in its own read slot.
    assign op_d    = {bus.rf_rdata_a, bus.rf_rdata_b, bus.rf_rdata_a};
    assign op_zero = {rs3_idx_q == '0, rs2_idx_q == '0, rs1_idx_q == '0};
    assign op_en   = {cap3 & ~flush, cap12 & ~flush, cap12 & ~flush};
    assign op_clr  = {flush | (cap12 & ~use_rs3_q), flush, flush};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        vx_gpr_operand_reg u_op (
            .clk      (clk),
            .reset_n  (reset_n),
            .en       (op_en[i]),
            .clr      (op_clr[i]),
            .idx_zero (op_zero[i]),
            .d        (op_d[i]),
            .q        (op_q[i])
        );
    end

    assign bus.req_ready    = (state_q == IDLE) && !flush;
    assign bus.rf_ren       = ren;
    assign bus.rf_raddr_a   = addr_a;
    assign bus.rf_raddr_b   = addr_b;
    assign bus.rsp_valid    = (state_q == RSP);
    assign bus.rsp_wid      = wid_q;
    assign bus.rsp_tag      = tag_q;
    assign bus.rsp_rs1_data = op_q[0];
    assign bus.rsp_rs2_data = op_q[1];
    assign bus.rsp_rs3_data = op_q[2];
    assign busy             = (state_q != IDLE);
endmodule

// File: tb/tb_vx_gpr_read_ctrl.sv
// Bench for vx_gpr_read_ctrl: transaction-level latency model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_vx_gpr_read_ctrl;
    import vx_gpr_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    logic busy;
    int   n_tests = 0;
    int   n_fail  = 0;

    vx_gpr_read_ctrl_if bus ();

    vx_gpr_read_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Bank contents; reads return one cycle after rf_ren, noise otherwise.
    operand_t mem [0:(1<<RF_ADDR_W)-1];

    function automatic operand_t rnd_op();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    always @(posedge clk) begin
        logic ren;
        logic [RF_ADDR_W-1:0] a, b;
        ren = bus.rf_ren;
        a   = bus.rf_raddr_a;
        b   = bus.rf_raddr_b;
        #1;
        bus.rf_rdata_a = ren ? mem[a] : rnd_op();
        bus.rf_rdata_b = ren ? mem[b] : rnd_op();
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a transaction is live from acceptance; response appears 2 or 3
    // cycles after acceptance and persists until taken. Expected operands
    // come straight from bank contents at acceptance time.
    bit                   m_active = 1'b0;
    int                   m_age = 0;
    bit                   m_use3;
    logic [WID_W-1:0]     m_wid;
    logic [REG_W-1:0]     m_rs3;
    logic [TAG_WIDTH-1:0] m_tag;
    operand_t             m_d1, m_d2, m_d3;

    always @(negedge clk) begin
        logic e_ren, e_rv, skip_rf;
        logic [RF_ADDR_W-1:0] e_a, e_b;
        if (!reset_n) m_active = 1'b0;
        e_rv    = m_active && (m_age >= (m_use3 ? 3 : 2));
        skip_rf = 1'b0;
        e_ren   = 1'b0;
        e_a     = '0;
        e_b     = '0;
        if (!m_active) begin
            if (bus.req_valid && !flush) begin
                e_ren = 1'b1;
                e_a   = {bus.req_wid, bus.req_rs1};
                e_b   = {bus.req_wid, bus.req_rs2};
            end
        end else if (m_age == 1 && m_use3) begin
            if (flush) skip_rf = 1'b1;
            else begin
                e_ren = 1'b1;
                e_a   = {m_wid, m_rs3};
            end
        end
        chk("m_busy", busy, m_active);
        chk("m_req_ready", bus.req_ready, !m_active && !flush);
        chk("m_rsp_valid", bus.rsp_valid, e_rv);
        if (!skip_rf) begin
            chk("m_rf_ren", bus.rf_ren, e_ren);
            chk("m_raddr_a", bus.rf_raddr_a, e_a);
            chk("m_raddr_b", bus.rf_raddr_b, e_b);
        end
        if (e_rv) begin
            chk("m_rsp_wid", bus.rsp_wid, m_wid);
            chk("m_rsp_tag", bus.rsp_tag, m_tag);
            chk("m_rs1", bus.rsp_rs1_data, m_d1);
            chk("m_rs2", bus.rsp_rs2_data, m_d2);
            chk("m_rs3", bus.rsp_rs3_data, m_d3);
        end
        if (reset_n) begin
            if (flush) m_active = 1'b0;
            else if (!m_active) begin
                if (bus.req_valid) begin
                    m_active = 1'b1;
                    m_age    = 1;
                    m_use3   = bus.req_use_rs3;
                    m_wid    = bus.req_wid;
                    m_rs3    = bus.req_rs3;
                    m_tag    = bus.req_tag;
                    m_d1 = (bus.req_rs1 == 0) ? '0 : mem[{bus.req_wid, bus.req_rs1}];
                    m_d2 = (bus.req_rs2 == 0) ? '0 : mem[{bus.req_wid, bus.req_rs2}];
                    m_d3 = (!bus.req_use_rs3 || bus.req_rs3 == 0) ? '0
                         : mem[{bus.req_wid, bus.req_rs3}];
                end
            end else if (e_rv && bus.rsp_ready) m_active = 1'b0;
            else if (m_age < 3) m_age++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic req(input int w, input int r1, input int r2, input int r3,
                       input bit u3, input int tg);
        bus.req_valid   = 1'b1;
        bus.req_wid     = w[WID_W-1:0];
        bus.req_rs1     = r1[REG_W-1:0];
        bus.req_rs2     = r2[REG_W-1:0];
        bus.req_rs3     = r3[REG_W-1:0];
        bus.req_use_rs3 = u3;
        bus.req_tag     = tg[TAG_WIDTH-1:0];
    endtask

    localparam operand_t D45 = 128'h0000_0045_1111_0045_2222_0045_3333_0045;
    localparam operand_t D47 = 128'h0000_0047_1111_0047_2222_0047_3333_0047;
    localparam operand_t D22 = 128'hAAAA_0022_BBBB_0022_CCCC_0022_DDDD_0022;
    localparam operand_t D23 = 128'h1234_0023_5678_0023_9ABC_0023_DEF0_0023;
    localparam operand_t D29 = 128'hCAFE_0029_BEEF_0029_F00D_0029_D00D_0029;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1<<RF_ADDR_W); i++) mem[i] = rnd_op();
        bus.req_valid = 0; bus.req_wid = 0; bus.req_rs1 = 0; bus.req_rs2 = 0;
        bus.req_rs3 = 0; bus.req_use_rs3 = 0; bus.req_tag = 0; bus.rsp_ready = 0;
        bus.rf_rdata_a = '0; bus.rf_rdata_b = '0;
        repeat (3) cyc();
        reset_n = 1'b1;
        smp();
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rs1", bus.rsp_rs1_data, 0);
        chk("rst_tag", bus.rsp_tag, 0);

        // Plain read, wid 2, rs1 5, rs2 7.
        cyc(); mem[7'h45] = D45; mem[7'h47] = D47;
        req(2, 5, 7, 0, 0, 8'hA5); bus.rsp_ready = 1;
        smp();
        chk("t1_ren", bus.rf_ren, 1);
        chk("t1_raddr_a", bus.rf_raddr_a, 7'h45);
        chk("t1_raddr_b", bus.rf_raddr_b, 7'h47);
        cyc(); bus.req_valid = 0;
        smp(); chk("t1_c1_rv", bus.rsp_valid, 0);
        chk("t1_c1_ren", bus.rf_ren, 0);
        cyc(); smp();
        chk("t1_c2_rv", bus.rsp_valid, 1);
        chk("t1_rs1", bus.rsp_rs1_data, D45);
        chk("t1_rs2", bus.rsp_rs2_data, D47);
        chk("t1_rs3", bus.rsp_rs3_data, 0);
        chk("t1_tag", bus.rsp_tag, 8'hA5);
        chk("t1_wid", bus.rsp_wid, 2);
        cyc(); smp(); chk("t1_c3_busy", busy, 0);

        // rs3 read, wid 1, then stall 5 cycles in the response.
        cyc(); mem[7'h22] = D22; mem[7'h23] = D23; mem[7'h29] = D29;
        req(1, 2, 3, 9, 1, 8'h3C); bus.rsp_ready = 0;
        smp();
        chk("t2_raddr_a0", bus.rf_raddr_a, 7'h22);
        chk("t2_raddr_b0", bus.rf_raddr_b, 7'h23);
        cyc(); bus.req_valid = 0;
        smp();
        chk("t2_ren1", bus.rf_ren, 1);
        chk("t2_raddr_a1", bus.rf_raddr_a, 7'h29);
        chk("t2_raddr_b1", bus.rf_raddr_b, 0);
        cyc(); smp(); chk("t2_c2_rv", bus.rsp_valid, 0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) bus.req_valid = 1;
            cyc(); smp();
            chk("t2_hold_rv", bus.rsp_valid, 1);
            chk("t2_hold_req_ready", bus.req_ready, 0);
            chk("t2_hold_ren", bus.rf_ren, 0);
            chk("t2_rs1", bus.rsp_rs1_data, D22);
            chk("t2_rs3", bus.rsp_rs3_data, D29);
        end
        cyc(); bus.req_valid = 0; bus.rsp_ready = 1;
        smp(); chk("t2_take_rv", bus.rsp_valid, 1);
        cyc(); smp(); chk("t2_idle", busy, 0);

        // x0 operand ignores bank data.
        cyc(); mem[7'h00] = '1; mem[7'h03] = '1;
        req(0, 0, 3, 0, 0, 8'h11);
        cyc(); bus.req_valid = 0;
        cyc(); smp();
        chk("t3_rv", bus.rsp_valid, 1);
        chk("t3_rs1_x0", bus.rsp_rs1_data, 0);
        chk("t3_rs2", bus.rsp_rs2_data, {128{1'b1}});

        // Flush in CAP3 while a new request is waiting.
        cyc(); req(3, 1, 2, 4, 1, 8'h5A);
        cyc(); req(2, 5, 7, 0, 0, 8'h66);
        smp(); chk("t4_c1_req_ready", bus.req_ready, 0);
        cyc(); flush = 1;
        smp(); chk("t4_c2_req_ready", bus.req_ready, 0);
        cyc(); flush = 0;
        smp();
        chk("t4_c3_busy", busy, 0);
        chk("t4_c3_rv", bus.rsp_valid, 0);
        chk("t4_c3_accept", bus.req_ready && bus.rf_ren, 1);
        cyc(); bus.req_valid = 0;
        smp(); chk("t4_c4_rv", bus.rsp_valid, 0);
        cyc(); smp();
        chk("t4_c5_rv", bus.rsp_valid, 1);
        chk("t4_c5_tag", bus.rsp_tag, 8'h66);
        chk("t4_c5_rs1", bus.rsp_rs1_data, D45);

        // Reset pulse while in CAP12.
        cyc(); req(2, 5, 7, 9, 1, 8'h77);
        cyc(); bus.req_valid = 0; reset_n = 0;
        smp(); chk("t5_in_rst_busy", busy, 0);
        cyc(); reset_n = 1;
        smp();
        chk("t5_busy", busy, 0);
        chk("t5_rv", bus.rsp_valid, 0);
        chk("t5_ren", bus.rf_ren, 0);
        chk("t5_req_ready", bus.req_ready, 1);
        chk("t5_tag", bus.rsp_tag, 0);

        // Random traffic against the model.
        for (int i = 0; i < (1<<RF_ADDR_W); i++) mem[i] = rnd_op();
        for (int c = 0; c < 3000; c++) begin
            cyc();
            bus.req_valid   = ($urandom_range(0, 1) == 1);
            bus.req_wid     = WID_W'($urandom_range(0, NUM_WARPS-1));
            bus.req_rs1     = ($urandom_range(0, 7) == 0) ? '0 : REG_W'($urandom());
            bus.req_rs2     = ($urandom_range(0, 7) == 0) ? '0 : REG_W'($urandom());
            bus.req_rs3     = ($urandom_range(0, 7) == 0) ? '0 : REG_W'($urandom());
            bus.req_use_rs3 = ($urandom_range(0, 2) == 0);
            bus.req_tag     = TAG_WIDTH'($urandom());
            bus.rsp_ready   = ($urandom_range(0, 9) < 7);
            flush           = ($urandom_range(0, 31) == 0);
        end
        cyc(); bus.req_valid = 0; flush = 0; bus.rsp_ready = 1;
        repeat (6) cyc();
        smp(); chk("end_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
